// File: rtl/mips_pipe_pkg.sv
// Shared types for the MIPS pipeline front end: decoded control word, NOP encoding
// and the stall-controller FSM state classes.
package mips_pipe_pkg;

  localparam int CTRL_WIDTH = 10;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads on write_en, holds otherwise, and a flush
// replaces the slot with an invalid NOP. Synchronous active-high reset.
module ifid_reg
  import mips_pipe_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 write_en,
  input  logic [BIT_WIDTH-1:0] instr,
  input  logic [BIT_WIDTH-1:0] pc4,
  output logic [BIT_WIDTH-1:0] instr_r,
  output logic [BIT_WIDTH-1:0] pc4_r,
  output logic                 valid_r
);

  // Flush outranks the hold request so a redirect always kills the wrong-path fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_r <= {BIT_WIDTH{1'b0}};
      pc4_r   <= {BIT_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (flush) begin
      instr_r <= BIT_WIDTH'(NOP_INSTR);
      pc4_r   <= {BIT_WIDTH{1'b0}};
      valid_r <= 1'b0;
    end else if (write_en) begin
      instr_r <= instr;
      pc4_r   <= pc4;
      valid_r <= 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl_chk.sv
// Simulation checker for the load-use handshake: a stall request must come with
// both PC and IF/ID writes disabled.
module pipeline_stall_ctrl_chk (
  input logic clk,
  input logic rst,
  input logic set_HDU,
  input logic PCWrite,
  input logic Write_IFID
);

  // A bubble without freezing the front end would drop or duplicate an instruction.
  a_stall_freezes_front : assert property (@(posedge clk) disable iff (rst)
    set_HDU |-> (!PCWrite && !Write_IFID))
    else $error("illegal handshake: set_HDU=1 with PCWrite=%0b Write_IFID=%0b", PCWrite, Write_IFID);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Front-end stall/flush controller: PC, IF/ID, ID/EX bubble and stall watchdog.
// Optional STALL_PERF_CNT_EN adds saturating stall/flush event counters.
module pipeline_stall_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int                   BIT_WIDTH = 32,
  parameter int                   CTRL_W    = 10,
  parameter logic [BIT_WIDTH-1:0] RESET_PC  = {BIT_WIDTH{1'b0}},
  parameter int                   MAX_STALL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_HDU,
  input  logic                 PCWrite,
  input  logic                 Write_IFID,
  input  logic                 branch_taken_i,
  input  logic [BIT_WIDTH-1:0] branch_target_i,
  input  logic [BIT_WIDTH-1:0] instr_i,
  input  logic [CTRL_W-1:0]    ctrl_id_i,
  output logic [BIT_WIDTH-1:0] pc_o,
  output logic [BIT_WIDTH-1:0] instr_ifid_o,
  output logic [BIT_WIDTH-1:0] pc4_ifid_o,
  output logic                 valid_ifid_o,
  output logic [CTRL_W-1:0]    ctrl_idex_o,
  output logic                 bubble_idex_o,
  output logic                 stall_timeout_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          flush_cnt_o
`endif
);

  localparam int               CNT_W   = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

  logic [BIT_WIDTH-1:0] pc_r;
  logic [BIT_WIDTH-1:0] pc_plus4_s;
  logic                 valid_ifid_s;
  logic [CTRL_W-1:0]    ctrl_idex_r;
  logic                 bubble_idex_r;
  logic                 stall_timeout_r;
  logic [CNT_W-1:0]     stall_cnt_r;
  logic [CNT_W-1:0]     stall_cnt_next_s;
  pipe_state_e          class_s;
  pipe_state_e          state_r;

  assign pc_plus4_s = pc_r + BIT_WIDTH'(4);

  // Edge classification: redirect beats stall beats normal flow.
  always_comb begin
    class_s = RUN;
    if (branch_taken_i) begin
      class_s = FLUSH;
    end else if (set_HDU) begin
      class_s = STALL;
    end else begin
      class_s = RUN;
    end
  end

  // Next stall-run length; a run only continues if the previous edge was also a stall.
  always_comb begin
    stall_cnt_next_s = CNT_W'(1);
    if (state_r == STALL) begin
      if (stall_cnt_r == MAX_CNT) begin
        stall_cnt_next_s = MAX_CNT;
      end else begin
        stall_cnt_next_s = stall_cnt_r + CNT_W'(1);
      end
    end else begin
      stall_cnt_next_s = CNT_W'(1);
    end
  end

  // Fetch PC: PCWrite gating applies whenever no redirect is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (class_s == FLUSH) begin
      pc_r <= branch_target_i;
    end else if (PCWrite) begin
      pc_r <= pc_plus4_s;
    end
  end

  ifid_reg #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_ifid_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (branch_taken_i),
    .write_en (Write_IFID),
    .instr    (instr_i),
    .pc4      (pc_plus4_s),
    .instr_r  (instr_ifid_o),
    .pc4_r    (pc4_ifid_o),
    .valid_r  (valid_ifid_s)
  );

  // ID/EX control slot: an empty IF/ID also turns into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_idex_r   <= {CTRL_W{1'b0}};
      bubble_idex_r <= 1'b1;
    end else begin
      case (class_s)
        RUN: begin
          ctrl_idex_r   <= valid_ifid_s ? ctrl_id_i : {CTRL_W{1'b0}};
          bubble_idex_r <= ~valid_ifid_s;
        end
        default: begin
          ctrl_idex_r   <= {CTRL_W{1'b0}};
          bubble_idex_r <= 1'b1;
        end
      endcase
    end
  end

  // FSM plus watchdog: timeout is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= RUN;
      stall_cnt_r     <= {CNT_W{1'b0}};
      stall_timeout_r <= 1'b0;
    end else begin
      state_r <= class_s;
      case (class_s)
        STALL: begin
          stall_cnt_r <= stall_cnt_next_s;
          if (stall_cnt_next_s == MAX_CNT) begin
            stall_timeout_r <= 1'b1;
          end
        end
        default: begin
          stall_cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_evt_r;
  logic [31:0] flush_evt_r;

  // Saturating event counters for stall and flush edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_evt_r <= 32'd0;
      flush_evt_r <= 32'd0;
    end else begin
      if ((class_s == STALL) && (stall_evt_r != 32'hFFFF_FFFF)) begin
        stall_evt_r <= stall_evt_r + 32'd1;
      end
      if ((class_s == FLUSH) && (flush_evt_r != 32'hFFFF_FFFF)) begin
        flush_evt_r <= flush_evt_r + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_evt_r;
  assign flush_cnt_o = flush_evt_r;
`endif

  assign pc_o            = pc_r;
  assign valid_ifid_o    = valid_ifid_s;
  assign ctrl_idex_o     = ctrl_idex_r;
  assign bubble_idex_o   = bubble_idex_r;
  assign stall_timeout_o = stall_timeout_r;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed + randomized bench for pipeline_stall_ctrl against a rule-level reference model.
module tb_pipeline_stall_ctrl;

  localparam int          BW = 32;
  localparam int          CW = 10;
  localparam int          MS = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          set_HDU = 1'b0;
  logic          PCWrite = 1'b1;
  logic          Write_IFID = 1'b1;
  logic          branch_taken_i = 1'b0;
  logic [BW-1:0] branch_target_i = 32'h0;
  logic [BW-1:0] instr_i = 32'h0;
  logic [CW-1:0] ctrl_id_i = 10'h0;
  logic [BW-1:0] pc_o, instr_ifid_o, pc4_ifid_o;
  logic          valid_ifid_o, bubble_idex_o, stall_timeout_o;
  logic [CW-1:0] ctrl_idex_o;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]   stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(
    .BIT_WIDTH(BW), .CTRL_W(CW), .RESET_PC(RST_PC), .MAX_STALL(MS)
  ) dut (
    .clk(clk), .rst(rst), .set_HDU(set_HDU), .PCWrite(PCWrite), .Write_IFID(Write_IFID),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .instr_i(instr_i), .ctrl_id_i(ctrl_id_i),
    .pc_o(pc_o), .instr_ifid_o(instr_ifid_o), .pc4_ifid_o(pc4_ifid_o),
    .valid_ifid_o(valid_ifid_o), .ctrl_idex_o(ctrl_idex_o),
    .bubble_idex_o(bubble_idex_o), .stall_timeout_o(stall_timeout_o)
`ifdef STALL_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  pipeline_stall_ctrl_chk u_chk (
    .clk(clk), .rst(rst), .set_HDU(set_HDU), .PCWrite(PCWrite), .Write_IFID(Write_IFID)
  );

  // Reference model state
  logic [31:0]   m_pc, m_instr, m_pc4;
  logic          m_valid, m_bub, m_to;
  logic [CW-1:0] m_ctrl;
  int            m_run;
  int unsigned   m_scnt, m_fcnt;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the rules of one clock edge to the model, using input values seen at that edge.
  task automatic model_step();
    logic [31:0] old_pc;
    logic        old_valid;
    if (rst) begin
      m_pc = RST_PC; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_ctrl = '0; m_bub = 1'b1; m_to = 1'b0; m_run = 0; m_scnt = 0; m_fcnt = 0;
    end else if (branch_taken_i) begin
      m_pc = branch_target_i; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_ctrl = '0; m_bub = 1'b1; m_run = 0; m_fcnt++;
    end else begin
      old_pc = m_pc;
      old_valid = m_valid;
      if (set_HDU) begin
        m_ctrl = '0; m_bub = 1'b1;
        m_run = (m_run < MS) ? m_run + 1 : MS;
        if (m_run == MS) m_to = 1'b1;
        m_scnt++;
      end else begin
        m_ctrl = old_valid ? ctrl_id_i : '0;
        m_bub = ~old_valid;
        m_run = 0;
      end
      if (Write_IFID) begin
        m_instr = instr_i; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
      end
      if (PCWrite) m_pc = old_pc + 32'd4;
    end
  endtask

  task automatic check_all();
    chk("pc_o", 64'(pc_o), 64'(m_pc));
    chk("instr_ifid_o", 64'(instr_ifid_o), 64'(m_instr));
    chk("pc4_ifid_o", 64'(pc4_ifid_o), 64'(m_pc4));
    chk("valid_ifid_o", 64'(valid_ifid_o), 64'(m_valid));
    chk("ctrl_idex_o", 64'(ctrl_idex_o), 64'(m_ctrl));
    chk("bubble_idex_o", 64'(bubble_idex_o), 64'(m_bub));
    chk("stall_timeout_o", 64'(stall_timeout_o), 64'(m_to));
`ifdef STALL_PERF_CNT_EN
    chk("stall_cnt_o", 64'(stall_cnt_o), 64'(m_scnt));
    chk("flush_cnt_o", 64'(flush_cnt_o), 64'(m_fcnt));
`endif
  endtask

  task automatic set_in(input logic r, input logic sh, input logic pw, input logic wi,
                        input logic bt, input logic [31:0] tgt);
    rst = r; set_HDU = sh; PCWrite = pw; Write_IFID = wi;
    branch_taken_i = bt; branch_target_i = tgt;
    instr_i = $urandom();
    ctrl_id_i = CW'($urandom());
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0); cycle(); end
  endtask
  task automatic do_free(input int n);
    for (int i = 0; i < n; i++) begin set_in(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0); cycle(); end
  endtask
  task automatic do_stall(input int n);
    for (int i = 0; i < n; i++) begin set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); cycle(); end
  endtask
  task automatic do_branch(input logic [31:0] tgt, input logic sh);
    set_in(1'b0, sh, ~sh, ~sh, 1'b1, tgt);
    cycle();
  endtask

  initial begin
    int r;
    int len;
    logic [31:0] tgt;

    // Reset state
    do_reset(2);
    chk("rst_pc", 64'(pc_o), 64'h0);
    chk("rst_bubble", 64'(bubble_idex_o), 64'h1);
    chk("rst_valid", 64'(valid_ifid_o), 64'h0);
    chk("rst_timeout", 64'(stall_timeout_o), 64'h0);

    // Three free-running fetches
    do_free(3);
    chk("free_pc", 64'(pc_o), 64'hC);
    chk("free_valid", 64'(valid_ifid_o), 64'h1);

    // Load-use stall at pc 0x8
    do_reset(2);
    do_free(2);
    chk("pre_stall_pc", 64'(pc_o), 64'h8);
    do_stall(1);
    chk("stall_pc_held", 64'(pc_o), 64'h8);
    chk("stall_ctrl_zero", 64'(ctrl_idex_o), 64'h0);
    chk("stall_bubble", 64'(bubble_idex_o), 64'h1);
    do_free(1);
    chk("resume_pc", 64'(pc_o), 64'hC);

    // Branch together with a stall request: flush wins
    do_branch(32'h40, 1'b1);
    chk("flush_pc", 64'(pc_o), 64'h40);
    chk("flush_valid", 64'(valid_ifid_o), 64'h0);
    do_free(1);
    chk("post_flush_pc", 64'(pc_o), 64'h44);

    // Watchdog fires on the 4th consecutive stall edge and is sticky
    do_stall(3);
    chk("wd_before", 64'(stall_timeout_o), 64'h0);
    do_stall(1);
    chk("wd_fire", 64'(stall_timeout_o), 64'h1);
    do_free(2);
    chk("wd_sticky", 64'(stall_timeout_o), 64'h1);
    do_reset(2);
    chk("wd_cleared", 64'(stall_timeout_o), 64'h0);

    // PC wrap-around
    do_branch(32'hFFFF_FFFC, 1'b0);
    do_free(1);
    chk("wrap_pc", 64'(pc_o), 64'h0);
    chk("wrap_pc4", 64'(pc4_ifid_o), 64'h0);

    // Reset during a stall run clears the run length
    do_stall(2);
    do_reset(1);
    chk("midstall_rst_pc", 64'(pc_o), 64'h0);
    do_stall(3);
    chk("midstall_no_wd", 64'(stall_timeout_o), 64'h0);
    do_stall(1);
    chk("midstall_wd", 64'(stall_timeout_o), 64'h1);

`ifdef STALL_PERF_CNT_EN
    do_reset(2);
    do_stall(3);
    do_free(1);
    do_branch(32'h100, 1'b0);
    do_branch(32'h200, 1'b0);
    chk("perf_stall", 64'(stall_cnt_o), 64'd3);
    chk("perf_flush", 64'(flush_cnt_o), 64'd2);
`endif

    // Randomized legal traffic
    do_reset(2);
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        do_reset(1);
      end else if (r < 12) begin
        tgt = $urandom() & 32'hFFFF_FFFC;
        do_branch(tgt, ($urandom_range(0, 1) == 1));
      end else if (r < 30) begin
        len = int'($urandom_range(1, 6));
        do_stall(len);
      end else begin
        set_in(1'b0, 1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1'b0, 32'h0);
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
